// File: rtl/rename_retire_queue_pkg.sv
// ----------------------------------------------------------------------------
// rename_retire_queue_pkg
//   Shared definitions for the rename retire queue and the RenameRF it frees
//   names into: default name/tag widths, queue depth, and a geometry helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package rename_retire_queue_pkg;

    localparam int RRQ_NAME_WIDTH = 1;
    localparam int RRQ_DEPTH      = 4;
    localparam int RRQ_TAG_WIDTH  = 2;

    // True when a tag of tag_width bits addresses each of depth entries exactly once.
    function automatic logic depth_matches_tag(input int depth, input int tag_width);
        return (depth == (32'sd1 << tag_width)) && (depth >= 32'sd2);
    endfunction

endpackage

// File: rtl/rename_retire_queue_chk.sv
// ----------------------------------------------------------------------------
// rename_retire_queue_chk
//   Simulation-only geometry check for the retire queue: depth must equal
//   2**tag_width so that pointer wrap and tag indexing line up.
//   Ports: CLK (clock), RST (active-high reset, disables the check).
// ----------------------------------------------------------------------------
module rename_retire_queue_chk
    import rename_retire_queue_pkg::*;
#(
    parameter int depth     = RRQ_DEPTH,
    parameter int tag_width = RRQ_TAG_WIDTH
)
(
    input logic CLK,
    input logic RST
);

    a_geometry: assert property (@(posedge CLK) disable iff (RST)
                                 depth_matches_tag(depth, tag_width));

endmodule

// File: rtl/rename_retire_queue.sv
// ----------------------------------------------------------------------------
// rename_retire_queue
//   In-order retire queue behind RenameRF. Names are recorded in program
//   order at allocation, marked done on writeback, and retired from the head
//   one per cycle by pulsing FE/NAME_F into RenameRF.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   ENQ_E, ENQ_NAME     enqueue request and allocated name
//   ENQ_READY, ENQ_TAG  queue not full, tag the next enqueue receives
//   WB_E, WB_TAG        writeback complete for entry WB_TAG
//   RETIRE_EN           retire permitted this cycle
//   FLUSH               discard all entries
//   FE, NAME_F          registered free pulse and name to RenameRF
//   EMPTY, COUNT        occupancy, derived from registered pointers only
// ----------------------------------------------------------------------------
module rename_retire_queue
    import rename_retire_queue_pkg::*;
#(
    parameter int name_width = RRQ_NAME_WIDTH,
    parameter int depth      = RRQ_DEPTH,
    parameter int tag_width  = RRQ_TAG_WIDTH
)
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENQ_E,
    input  logic [name_width-1:0] ENQ_NAME,
    output logic                  ENQ_READY,
    output logic [tag_width-1:0]  ENQ_TAG,
    input  logic                  WB_E,
    input  logic [tag_width-1:0]  WB_TAG,
    input  logic                  RETIRE_EN,
    input  logic                  FLUSH,
    output logic                  FE,
    output logic [name_width-1:0] NAME_F,
    output logic                  EMPTY,
    output logic [tag_width:0]    COUNT
);

    // Pointers carry one extra bit so that full (distance = depth) and
    // empty (distance = 0) are distinguishable with equal indices.
    localparam int               PTR_W      = tag_width + 1;
    localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(depth);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [name_width-1:0] name_mem_r [depth];
    logic [depth-1:0]      valid_r;
    logic [depth-1:0]      done_r;
    logic                  fe_r;
    logic [name_width-1:0] name_f_r;

    logic [PTR_W-1:0]      count_s;
    logic [tag_width-1:0]  head_idx_s;
    logic [tag_width-1:0]  tail_idx_s;
    logic                  enq_ready_s;
    logic                  do_enq_s;
    logic                  do_retire_s;
    logic                  do_wb_s;

    // Occupancy and per-cycle event qualification; FLUSH masks every other event.
    always_comb begin
        count_s     = tail_r - head_r;
        head_idx_s  = head_r[tag_width-1:0];
        tail_idx_s  = tail_r[tag_width-1:0];
        enq_ready_s = (count_s != FULL_COUNT);
        do_enq_s    = 1'b0;
        do_retire_s = 1'b0;
        do_wb_s     = 1'b0;
        if (FLUSH) begin
            do_enq_s    = 1'b0;
            do_retire_s = 1'b0;
            do_wb_s     = 1'b0;
        end else begin
            do_enq_s    = ENQ_E && enq_ready_s;
            do_retire_s = RETIRE_EN && valid_r[head_idx_s] && done_r[head_idx_s];
            // A writeback landing on the entry that retires this cycle is dropped
            // so the freed slot does not come back marked done.
            do_wb_s     = WB_E && valid_r[WB_TAG] &&
                          !(do_retire_s && (WB_TAG == head_idx_s));
        end
    end

    // Queue state, pointers and registered free outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_r   <= '0;
            tail_r   <= '0;
            valid_r  <= '0;
            done_r   <= '0;
            fe_r     <= 1'b0;
            name_f_r <= '0;
            for (int i = 0; i < depth; i++) begin
                name_mem_r[i] <= '0;
            end
        end else if (FLUSH) begin
            // Squashed names are not freed here; recovery is handled elsewhere.
            head_r  <= '0;
            tail_r  <= '0;
            valid_r <= '0;
            done_r  <= '0;
            fe_r    <= 1'b0;
        end else begin
            fe_r <= do_retire_s;
            if (do_retire_s) begin
                name_f_r            <= name_mem_r[head_idx_s];
                valid_r[head_idx_s] <= 1'b0;
                done_r[head_idx_s]  <= 1'b0;
                head_r              <= head_r + PTR_ONE;
            end
            if (do_wb_s) begin
                done_r[WB_TAG] <= 1'b1;
            end
            // Enqueue never aliases the retiring or written-back slot: the tail
            // slot is only valid when the queue is full, and then enqueue is blocked.
            if (do_enq_s) begin
                name_mem_r[tail_idx_s] <= ENQ_NAME;
                valid_r[tail_idx_s]    <= 1'b1;
                done_r[tail_idx_s]     <= 1'b0;
                tail_r                 <= tail_r + PTR_ONE;
            end
        end
    end

    assign ENQ_READY = enq_ready_s;
    assign ENQ_TAG   = tail_idx_s;
    assign EMPTY     = (count_s == '0);
    assign COUNT     = count_s;
    assign FE        = fe_r;
    assign NAME_F    = name_f_r;

    rename_retire_queue_chk #(
        .depth     (depth),
        .tag_width (tag_width)
    ) u_chk (
        .CLK (CLK),
        .RST (RST)
    );

endmodule
